// File: rtl/i2c_master.sv
// i2c_master: byte-level single-master I2C controller, one host command per byte.
// SCL is push-pull; SDA is only ever pulled low or released (open-drain).
module i2c_master #(
  parameter int unsigned DIV = 41
) (
  input  logic       in_clk,
  input  logic       in_rst,
  output logic       out_scl,
  inout  wire        io_sda,
  output logic       out_sda_dir,
  input  logic       in_cmd_valid,
  output logic       out_cmd_ready,
  input  logic       in_cmd_start,
  input  logic       in_cmd_stop,
  input  logic       in_cmd_read,
  input  logic       in_cmd_ack,
  input  logic [7:0] in_cmd_data,
  output logic       out_rsp_valid,
  output logic [7:0] out_rsp_data,
  output logic       out_rsp_nack,
  output logic       out_busy
);
  localparam int unsigned QW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_RSTART, S_BIT, S_STOP, S_HOLD} state_t;

  state_t        r_state;
  logic [QW-1:0] r_qcnt;
  logic [1:0]    r_ph;
  logic [3:0]    r_bit;
  logic          r_read, r_ack, r_stop, r_ack_smp;
  logic [7:0]    r_data, r_shift, r_rsp_data;
  logic          r_scl, r_sda_dir, r_ready, r_rsp_valid, r_rsp_nack, r_busy;
  logic [1:0]    r_sync;
  logic          w_counting, w_wrap, w_accept, w_sda_raw;

  // Line level for bit n of a byte (0..7 data MSB first, 8 = ACK); 1 = release.
  function automatic logic f_rel(input logic [3:0] n, input logic rd, input logic ack,
                                 input logic [7:0] d);
    if (n == 4'd8) return rd ? ack : 1'b1;
    return rd ? 1'b1 : d[3'd7 - n[2:0]];
  endfunction

  assign io_sda        = r_sda_dir ? 1'b0 : 1'bz;
  assign w_sda_raw     = !(io_sda == 1'b0);
  assign w_counting    = (r_state != S_IDLE) && (r_state != S_HOLD);
  assign w_wrap        = w_counting && (r_qcnt == QW'(DIV - 1));
  assign w_accept      = in_cmd_valid && r_ready;

  assign out_scl       = r_scl;
  assign out_sda_dir   = r_sda_dir;
  assign out_cmd_ready = r_ready;
  assign out_rsp_valid = r_rsp_valid;
  assign out_rsp_data  = r_rsp_data;
  assign out_rsp_nack  = r_rsp_nack;
  assign out_busy      = r_busy;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state     <= S_IDLE;
      r_qcnt      <= '0;
      r_ph        <= '0;
      r_bit       <= '0;
      r_read      <= 1'b0;
      r_ack       <= 1'b0;
      r_stop      <= 1'b0;
      r_ack_smp   <= 1'b0;
      r_data      <= '0;
      r_shift     <= '0;
      r_rsp_data  <= '0;
      r_scl       <= 1'b1;
      r_sda_dir   <= 1'b0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_nack  <= 1'b0;
      r_busy      <= 1'b0;
      r_sync      <= '1;
    end else begin
      r_sync      <= {r_sync[0], w_sda_raw};
      r_rsp_valid <= 1'b0;
      if (!w_counting || w_wrap) r_qcnt <= '0;
      else                       r_qcnt <= r_qcnt + QW'(1);

      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_accept) begin
            r_read  <= in_cmd_read;
            r_ack   <= in_cmd_ack;
            r_stop  <= in_cmd_stop;
            r_data  <= in_cmd_data;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_ph    <= '0;
            r_bit   <= '0;
            if (r_state == S_IDLE) begin
              r_state   <= S_START;
              r_sda_dir <= 1'b1;
            end else if (in_cmd_start) begin
              r_state   <= S_RSTART;
              r_sda_dir <= 1'b0;
            end else begin
              r_state   <= S_BIT;
              r_sda_dir <= !f_rel(4'd0, in_cmd_read, in_cmd_ack, in_cmd_data);
            end
          end
        end
        S_START: begin
          if (w_wrap) begin
            r_ph <= r_ph + 2'd1;
            if (r_ph == 2'd1) begin
              r_scl     <= 1'b0;
              r_state   <= S_BIT;
              r_ph      <= '0;
              r_sda_dir <= !f_rel(4'd0, r_read, r_ack, r_data);
            end
          end
        end
        S_RSTART: begin
          if (w_wrap) begin
            r_ph <= r_ph + 2'd1;
            case (r_ph)
              2'd0:    r_scl     <= 1'b1;
              2'd1:    r_sda_dir <= 1'b1;
              2'd2:    r_scl     <= 1'b0;
              default: begin
                r_state   <= S_BIT;
                r_sda_dir <= !f_rel(4'd0, r_read, r_ack, r_data);
              end
            endcase
          end
        end
        S_BIT: begin
          // Sample on the last cycle of the first SCL-high quarter.
          if (w_wrap && r_ph == 2'd2) begin
            if (r_bit == 4'd8) r_ack_smp <= r_sync[1];
            else               r_shift   <= {r_shift[6:0], r_sync[1]};
          end
          if (w_wrap) begin
            r_ph <= r_ph + 2'd1;
            if (r_ph == 2'd1) r_scl <= 1'b1;
            if (r_ph == 2'd3) begin
              r_scl <= 1'b0;
              if (r_bit == 4'd8) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= r_shift;
                r_rsp_nack  <= r_ack_smp;
                if (r_stop) begin
                  r_state   <= S_STOP;
                  r_sda_dir <= 1'b1;
                end else begin
                  r_state <= S_HOLD;
                  r_ready <= 1'b1;
                end
              end else begin
                r_bit     <= r_bit + 4'd1;
                r_sda_dir <= !f_rel(r_bit + 4'd1, r_read, r_ack, r_data);
              end
            end
          end
        end
        S_STOP: begin
          if (w_wrap) begin
            r_ph <= r_ph + 2'd1;
            case (r_ph)
              2'd0:    r_scl     <= 1'b1;
              2'd1:    r_sda_dir <= 1'b0;
              2'd2:    ;
              default: begin
                r_busy  <= 1'b0;
                r_ready <= 1'b1;
                r_state <= S_IDLE;
              end
            endcase
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: a bus monitor/slave model decodes SCL/SDA and
// each command is checked against expectations derived from the command and slave setup.
`timescale 1ns/1ps
module tb_i2c_master;
  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0;
  logic       cmd_read = 1'b0, cmd_ack = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       scl, sda_dir, cmd_ready, rsp_valid, rsp_nack, busy;
  logic [7:0] rsp_data;
  wire        sda;
  logic       sl_low = 1'b0;

  assign sda = sl_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_master #(.DIV(DIV)) dut (
    .in_clk(clk), .in_rst(rst), .out_scl(scl), .io_sda(sda), .out_sda_dir(sda_dir),
    .in_cmd_valid(cmd_valid), .out_cmd_ready(cmd_ready), .in_cmd_start(cmd_start),
    .in_cmd_stop(cmd_stop), .in_cmd_read(cmd_read), .in_cmd_ack(cmd_ack),
    .in_cmd_data(cmd_data), .out_rsp_valid(rsp_valid), .out_rsp_data(rsp_data),
    .out_rsp_nack(rsp_nack), .out_busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned errors = 0, checks = 0;

  // Slave configuration (written by tests) and bus monitor state (written by monitor only).
  logic        sl_read = 1'b0, sl_ack_en = 1'b0;
  logic [7:0]  sl_byte = '0;
  int unsigned clr_req = 0, clr_seen = 0;
  logic        p_scl = 1'b1, p_sda = 1'b1, line, rise_ok = 1'b0, sl_act = 1'b0;
  logic [2:0]  bi;
  int unsigned n_start = 0, n_stop = 0, bitcnt = 0, t_rise = 0;
  logic        q_bit[$], q_dir[$];
  int unsigned q_hi[$], q_per[$];

  always @(negedge clk) begin
    line = (sda !== 1'b0);
    if (clr_req != clr_seen) begin
      clr_seen = clr_req;
      n_start = 0; n_stop = 0; rise_ok = 1'b0;
      q_bit.delete(); q_dir.delete(); q_hi.delete(); q_per.delete();
    end
    if (rst) begin
      sl_act = 1'b0; bitcnt = 0; sl_low = 1'b0;
    end else begin
      if (p_scl && scl && (line != p_sda)) begin
        if (!line) begin
          n_start++; sl_act = 1'b1; bitcnt = 0; rise_ok = 1'b0;
          q_bit.delete(); q_dir.delete(); q_hi.delete(); q_per.delete();
        end else begin
          n_stop++; sl_act = 1'b0; bitcnt = 0;
        end
      end
      if (!p_scl && scl) begin
        q_bit.push_back(line);
        q_dir.push_back(sda_dir);
        if (rise_ok) q_per.push_back(cyc - t_rise);
        t_rise = cyc; rise_ok = 1'b1;
        if (sl_act && sl_read && bitcnt == 8 && line) sl_act = 1'b0;
        bitcnt++;
      end
      if (p_scl && !scl) begin
        if (rise_ok) q_hi.push_back(cyc - t_rise);
        if (bitcnt >= 9) bitcnt = 0;
      end
      if (!scl) begin
        bi = 3'(7 - bitcnt);
        if (!sl_act)      sl_low = 1'b0;
        else if (sl_read) sl_low = (bitcnt < 8) && !sl_byte[bi];
        else              sl_low = (bitcnt == 8) && sl_ack_en;
      end
    end
    p_scl = scl;
    p_sda = line;
  end

  // Bench-level view of the bus: does the master own it, is the slave addressed.
  logic m_held = 1'b0, m_act = 1'b0;

  task automatic do_cmd(input string nm, input logic st, input logic sp, input logic rd,
                        input logic ak, input logic [7:0] d, input logic sack,
                        input logic [7:0] sbyte);
    int unsigned pre, c0, n, w, bad;
    logic        act, exp_ack;
    logic [7:0]  exp_byte;
    logic [8:0]  got_bits, got_dir, exp_dir;
    pre      = !m_held ? 2 : (st ? 4 : 0);
    act      = (pre != 0) ? 1'b1 : m_act;
    exp_byte = rd ? (act ? sbyte : 8'hFF) : d;
    exp_ack  = rd ? ak : !(sack && act);
    exp_dir  = rd ? {8'h00, !ak} : {~d, 1'b0};
    sl_read = rd; sl_ack_en = sack; sl_byte = sbyte;
    clr_req++;
    @(negedge clk); @(negedge clk);
    cmd_valid = 1'b1; cmd_start = st; cmd_stop = sp; cmd_read = rd; cmd_ack = ak; cmd_data = d;
    w = 0;
    while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s ready_wait: ready=%b want 1", nm, cmd_ready); end
    @(negedge clk);
    c0 = cyc;
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s accept: ready=%b busy=%b want 0 1", nm, cmd_ready, busy);
    end
    n = (pre + 36) * DIV;
    w = 0;
    while (!rsp_valid && w < 100 * DIV) begin @(negedge clk); w++; end
    checks++;
    if (cyc - c0 !== n) begin errors++; $display("FAIL %s rsp_latency: got %0d want %0d", nm, cyc - c0, n); end
    checks++;
    if (rsp_nack !== exp_ack) begin errors++; $display("FAIL %s rsp_nack: got %b want %b", nm, rsp_nack, exp_ack); end
    if (rd) begin
      checks++;
      if (rsp_data !== exp_byte) begin errors++; $display("FAIL %s rsp_data: got %h want %h", nm, rsp_data, exp_byte); end
    end
    if (!sp) begin
      checks++;
      if ({cmd_ready, busy, scl} !== 3'b110) begin
        errors++; $display("FAIL %s hold: ready/busy/scl=%b want 110", nm, {cmd_ready, busy, scl});
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s rsp_pulse: rsp_valid=%b want 0", nm, rsp_valid); end
    if (sp) begin
      w = 0;
      while (!cmd_ready && w < 100 * DIV) begin @(negedge clk); w++; end
      checks++;
      if (cyc - c0 !== n + 4 * DIV) begin
        errors++; $display("FAIL %s stop_done: got %0d want %0d cycles", nm, cyc - c0, n + 4 * DIV);
      end
      checks++;
      if ({busy, scl} !== 2'b01) begin errors++; $display("FAIL %s idle: busy/scl=%b want 01", nm, {busy, scl}); end
    end
    got_bits = '1; got_dir = '1;
    for (int i = 0; i < 9; i++) begin
      if (i < q_bit.size()) begin got_bits[8 - i] = q_bit[i]; got_dir[8 - i] = q_dir[i]; end
    end
    checks++;
    if (q_bit.size() != 9 + int'(sp) || got_bits !== {exp_byte, exp_ack}) begin
      errors++; $display("FAIL %s bus_bits: got %h (%0d rises) want %h (%0d rises)",
                         nm, got_bits, q_bit.size(), {exp_byte, exp_ack}, 9 + int'(sp));
    end
    checks++;
    if (got_dir !== exp_dir) begin errors++; $display("FAIL %s sda_drive: got %h want %h", nm, got_dir, exp_dir); end
    bad = 0;
    if (q_hi.size() < 9 || q_per.size() < 8) bad = 99;
    else begin
      for (int i = 0; i < 9; i++) if (q_hi[i] != 2 * DIV) bad++;
      for (int i = 0; i < 8; i++) if (q_per[i] != 4 * DIV) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s scl_timing: %0d bad phases want 0", nm, bad); end
    checks++;
    if (n_start != int'(pre != 0) || n_stop != int'(sp)) begin
      errors++; $display("FAIL %s start_stop: got %0d/%0d want %0d/%0d", nm, n_start, n_stop,
                         int'(pre != 0), int'(sp));
    end
    m_held = !sp;
    m_act  = act && !(rd && ak) && !sp;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({scl, sda_dir, cmd_ready, rsp_valid, rsp_nack, busy} !== 6'b101000 || rsp_data !== 8'h00) begin
      errors++; $display("FAIL reset_state: scl/dir/rdy/vld/nack/busy=%b data=%h want 101000 00",
                         {scl, sda_dir, cmd_ready, rsp_valid, rsp_nack, busy}, rsp_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_ack();
    do_cmd("wr_addr_ack", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA0, 1'b1, 8'h00);
  endtask

  task automatic test_write_nack_stop();
    do_cmd("wr_nack_stop", 1'b0, 1'b1, 1'b0, 1'b0, 8'hAA, 1'b0, 8'h00);
  endtask

  task automatic test_rstart_read();
    do_cmd("rs_addr", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA0, 1'b1, 8'h00);
    do_cmd("rs_rstart", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA1, 1'b1, 8'h00);
    do_cmd("rs_read_nack", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h5C);
  endtask

  task automatic test_reads();
    do_cmd("rd_addr", 1'b1, 1'b0, 1'b0, 1'b0, 8'hA1, 1'b1, 8'h00);
    do_cmd("rd_first", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h12);
    do_cmd("rd_last", 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h34);
  endtask

  task automatic test_reset_mid_byte();
    int unsigned w;
    sl_read = 1'b0; sl_ack_en = 1'b1; sl_byte = '0;
    clr_req++;
    @(negedge clk); @(negedge clk);
    cmd_valid = 1'b1; cmd_start = 1'b1; cmd_stop = 1'b0; cmd_read = 1'b0; cmd_data = 8'h96;
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (q_bit.size() < 5 && w < 100 * DIV) begin @(negedge clk); w++; end
    checks++;
    if (q_bit.size() < 5) begin errors++; $display("FAIL mid_reach_bit4: rises=%0d want 5", q_bit.size()); end
    repeat (DIV) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({scl, sda_dir} !== 2'b10) begin errors++; $display("FAIL mid_async: scl/dir=%b want 10", {scl, sda_dir}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL mid_after: ready/busy/vld=%b want 100", {cmd_ready, busy, rsp_valid});
    end
    m_held = 1'b0; m_act = 1'b0;
    do_cmd("after_reset", 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 8'h00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 14; i++) begin
      logic st, sp, rd, ak, sack;
      logic [7:0] d, sb;
      st   = 1'($urandom_range(0, 1));
      sp   = ($urandom_range(0, 3) == 0) || (i == 13);
      rd   = (!m_held || st) ? 1'b0 : 1'($urandom_range(0, 1));
      ak   = 1'($urandom_range(0, 1));
      sack = ($urandom_range(0, 3) != 0);
      d    = 8'($urandom);
      sb   = 8'($urandom);
      do_cmd("random", st, sp, rd, ak, d, sack, sb);
    end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_write_nack_stop();
    test_rstart_read();
    test_reads();
    test_reset_mid_byte();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
